// File: rtl/btn_panel_ctrl.sv
// btn_panel_ctrl: front-panel push-button conditioner.
// One shared slow tick drives N_BTN independent channels. Each channel runs a
// 2-FF synchroniser, a tick-sampled debouncer, a rising-edge press pulse,
// a long-press pulse and a toggle latch with a synchronous clear.
module btn_panel_ctrl #(
    parameter int N_BTN      = 2,
    parameter int CLK_DIV    = 100000,
    parameter int DEB_TICKS  = 10,
    parameter int LONG_TICKS = 100
) (
    input  logic             sys_clk,
    input  logic             rst_sw,
    input  logic [N_BTN-1:0] bt_in,
    input  logic [N_BTN-1:0] tog_clr,
    output logic             tick,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic [N_BTN-1:0] tog_state
);

    // Counter widths are sized from their limits with one spare bit.
    localparam int DIV_W  = $clog2(CLK_DIV) + 1;
    localparam int DEB_W  = $clog2(DEB_TICKS) + 1;
    localparam int HOLD_W = $clog2(LONG_TICKS) + 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_PRE   = DIV_W'(CLK_DIV - 2);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);

    // ------------------------------------------------------------------
    // Shared tick divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_reg;
    logic [DIV_W-1:0] div_cnt_next;
    logic             tick_reg;
    logic             tick_next;

    // Next divider count and the registered tick, which is high exactly in
    // the cycle the counter holds CLK_DIV-1 (decoded one count early).
    always_comb begin
        div_cnt_next = div_cnt_reg + DIV_W'(1);
        if (div_cnt_reg == DIV_LAST) begin
            div_cnt_next = '0;
        end
        tick_next = (div_cnt_reg == DIV_PRE);
    end

    // Divider state registers.
    always_ff @(posedge sys_clk or posedge rst_sw) begin
        if (rst_sw) begin
            div_cnt_reg <= '0;
            tick_reg    <= 1'b0;
        end else begin
            div_cnt_reg <= div_cnt_next;
            tick_reg    <= tick_next;
        end
    end

    assign tick = tick_reg;

    // ------------------------------------------------------------------
    // Per-channel conditioning chain
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_ch
            logic              sync1_reg;
            logic              sync2_reg;
            logic [DEB_W-1:0]  deb_cnt_reg;
            logic [DEB_W-1:0]  deb_cnt_next;
            logic              level_reg;
            logic              level_next;
            logic              level_dly_reg;
            logic              press_reg;
            logic              press_next;
            logic [HOLD_W-1:0] hold_cnt_reg;
            logic [HOLD_W-1:0] hold_cnt_next;
            logic              long_reg;
            logic              long_next;
            logic              tog_reg;
            logic              tog_next;

            // Two-stage synchroniser for the raw asynchronous button level.
            always_ff @(posedge sys_clk or posedge rst_sw) begin
                if (rst_sw) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                end else begin
                    sync1_reg <= bt_in[gi];
                    sync2_reg <= sync1_reg;
                end
            end

            // Debounce: a differing level must persist for DEB_TICKS
            // consecutive ticks; any agreeing tick restarts the count.
            always_comb begin
                deb_cnt_next = deb_cnt_reg;
                level_next   = level_reg;
                if (tick_reg) begin
                    if (sync2_reg != level_reg) begin
                        if (deb_cnt_reg == DEB_LAST) begin
                            level_next   = sync2_reg;
                            deb_cnt_next = '0;
                        end else begin
                            deb_cnt_next = deb_cnt_reg + DEB_W'(1);
                        end
                    end else begin
                        deb_cnt_next = '0;
                    end
                end
            end

            // Debounced level, its one-cycle-delayed copy and the press pulse
            // that fires the cycle after the accepted level rises.
            always_comb begin
                press_next = level_reg & ~level_dly_reg;
            end

            // Debouncer and press-edge registers.
            always_ff @(posedge sys_clk or posedge rst_sw) begin
                if (rst_sw) begin
                    deb_cnt_reg   <= '0;
                    level_reg     <= 1'b0;
                    level_dly_reg <= 1'b0;
                    press_reg     <= 1'b0;
                end else begin
                    deb_cnt_reg   <= deb_cnt_next;
                    level_reg     <= level_next;
                    level_dly_reg <= level_reg;
                    press_reg     <= press_next;
                end
            end

            // Long press: count ticks while held, saturate at LONG_TICKS and
            // pulse only on the step that reaches it; a low level clears it.
            always_comb begin
                hold_cnt_next = hold_cnt_reg;
                long_next     = 1'b0;
                if (!level_reg) begin
                    hold_cnt_next = '0;
                end else if (tick_reg && (hold_cnt_reg != HOLD_MAX)) begin
                    hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                    if (hold_cnt_reg == HOLD_LAST) begin
                        long_next = 1'b1;
                    end
                end
            end

            // Long-press registers.
            always_ff @(posedge sys_clk or posedge rst_sw) begin
                if (rst_sw) begin
                    hold_cnt_reg <= '0;
                    long_reg     <= 1'b0;
                end else begin
                    hold_cnt_reg <= hold_cnt_next;
                    long_reg     <= long_next;
                end
            end

            // Toggle latch: clear has priority over a coincident press.
            always_comb begin
                tog_next = tog_reg;
                if (tog_clr[gi]) begin
                    tog_next = 1'b0;
                end else if (press_reg) begin
                    tog_next = ~tog_reg;
                end
            end

            // Toggle register.
            always_ff @(posedge sys_clk or posedge rst_sw) begin
                if (rst_sw) begin
                    tog_reg <= 1'b0;
                end else begin
                    tog_reg <= tog_next;
                end
            end

            assign btn_level[gi]   = level_reg;
            assign press_pulse[gi] = press_reg;
            assign long_pulse[gi]  = long_reg;
            assign tog_state[gi]   = tog_reg;
        end
    endgenerate

endmodule

// File: tb/tb_btn_panel_ctrl.sv
// Directed bench for btn_panel_ctrl with a pulse scoreboard: each press or
// long-press the stimulus expects is queued with a cycle window, and a
// monitor pops and checks the queue whenever a pulse appears.
module tb_btn_panel_ctrl;
    localparam int N_BTN      = 2;
    localparam int CLK_DIV    = 4;
    localparam int DEB_TICKS  = 3;
    localparam int LONG_TICKS = 8;

    // Press pulse window (edges after the bt_in change): 2 sync stages, then
    // DEB_TICKS ticks whose first one may land anywhere in a tick period.
    localparam int P_LO = 2 + (DEB_TICKS - 1) * CLK_DIV + 1;
    localparam int P_HI = 2 + DEB_TICKS * CLK_DIV + 4;
    // Long pulse follows the level rise (one edge before the press pulse)
    // by LONG_TICKS tick periods.
    localparam int L_LO = P_LO - 1 + LONG_TICKS * CLK_DIV;
    localparam int L_HI = P_HI - 1 + LONG_TICKS * CLK_DIV;

    logic             sys_clk;
    logic             rst_sw;
    logic [N_BTN-1:0] bt_in;
    logic [N_BTN-1:0] tog_clr;
    logic             tick;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] long_pulse;
    logic [N_BTN-1:0] tog_state;

    typedef struct {
        int kind;   // 0 = press, 1 = long
        int ch;
        int lo;
        int hi;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    btn_panel_ctrl #(
        .N_BTN     (N_BTN),
        .CLK_DIV   (CLK_DIV),
        .DEB_TICKS (DEB_TICKS),
        .LONG_TICKS(LONG_TICKS)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_sw     (rst_sw),
        .bt_in      (bt_in),
        .tog_clr    (tog_clr),
        .tick       (tick),
        .btn_level  (btn_level),
        .press_pulse(press_pulse),
        .long_pulse (long_pulse),
        .tog_state  (tog_state)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_pulse(input int kind, input int ch, input int lo, input int hi);
        exp_t e;
        e.kind = kind;
        e.ch   = ch;
        e.lo   = cyc + lo;
        e.hi   = cyc + hi;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every pulse seen must match the head of the queue.
    always @(negedge sys_clk) begin
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < N_BTN; c++) begin
                if ((k == 0) ? press_pulse[c] : long_pulse[c]) begin
                    checks++;
                    assert (exp_q.size() > 0) else begin
                        failures++;
                        $error("FAIL unexpected_pulse kind=%0d ch=%0d observed_cycle=%0d expected=none", k, c, cyc);
                    end
                    if (exp_q.size() > 0) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        checks++;
                        assert ((e.kind == k) && (e.ch == c)) else begin
                            failures++;
                            $error("FAIL pulse_id observed=kind%0d/ch%0d expected=kind%0d/ch%0d", k, c, e.kind, e.ch);
                        end
                        checks++;
                        assert ((cyc >= e.lo) && (cyc <= e.hi)) else begin
                            failures++;
                            $error("FAIL pulse_time kind=%0d ch=%0d observed_cycle=%0d expected=%0d..%0d", k, c, cyc, e.lo, e.hi);
                        end
                        $display("pulse kind=%0d ch=%0d at cycle %0d window %0d..%0d", k, c, cyc, e.lo, e.hi);
                    end
                end
            end
        end
    end

    initial begin
        bit seen;
        rst_sw  = 1'b1;
        bt_in   = '0;
        tog_clr = '0;
        repeat (3) @(negedge sys_clk);
        check("reset_outs", {tick, btn_level, press_pulse, long_pulse, tog_state}, 32'd0);
        $display("reset state checked");

        // 1: idle run. Sample j is in the (j+1)th cycle after release, so the
        // tick must appear when (j+1) is a multiple of CLK_DIV.
        rst_sw = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge sys_clk);
            check("tick_phase", 32'(tick), 32'(((j + 1) % CLK_DIV) == 0));
            check("idle_outs", {btn_level, press_pulse, long_pulse, tog_state}, 32'd0);
        end
        $display("idle tick pattern checked");

        // 2: clean held press on ch0, long enough for one long pulse.
        expect_pulse(0, 0, P_LO, P_HI);
        expect_pulse(1, 0, L_LO, L_HI);
        bt_in[0] = 1'b1;
        repeat (40) @(negedge sys_clk);
        check("t2_level0_high", 32'(btn_level[0]), 32'd1);
        check("t2_tog0_set", 32'(tog_state[0]), 32'd1);
        repeat (20) @(negedge sys_clk);
        bt_in[0] = 1'b0;
        repeat (30) @(negedge sys_clk);
        check("t2_queue", exp_q.size(), 32'd0);
        check("t2_level0_low", 32'(btn_level[0]), 32'd0);
        check("t2_ch1_quiet", {30'd0, btn_level[1], tog_state[1]}, 32'd0);
        $display("step 2 ch0 press done");

        // 3: bouncing input never settles long enough to be accepted.
        for (int j = 0; j < 40; j++) begin
            if ((j % 3) == 0) bt_in[0] = ~bt_in[0];
            @(negedge sys_clk);
            check("t3_level0_low", 32'(btn_level[0]), 32'd0);
        end
        bt_in[0] = 1'b0;
        repeat (20) @(negedge sys_clk);
        check("t3_queue", exp_q.size(), 32'd0);
        check("t3_tog0_kept", 32'(tog_state[0]), 32'd1);
        $display("step 3 bounce rejected");

        // 4: long hold on ch1, exactly one press and one long pulse.
        expect_pulse(0, 1, P_LO, P_HI);
        expect_pulse(1, 1, L_LO, L_HI);
        bt_in[1] = 1'b1;
        repeat (150) @(negedge sys_clk);
        check("t4_queue", exp_q.size(), 32'd0);
        bt_in[1] = 1'b0;
        repeat (30) @(negedge sys_clk);
        check("t4_tog1_set", 32'(tog_state[1]), 32'd1);
        check("t4_level1_low", 32'(btn_level[1]), 32'd0);
        $display("step 4 ch1 long press done");

        // 5: clear, two short presses, then a press with clear in the pulse cycle.
        tog_clr[0] = 1'b1;
        @(negedge sys_clk);
        tog_clr[0] = 1'b0;
        @(negedge sys_clk);
        check("t5_cleared", 32'(tog_state[0]), 32'd0);
        for (int p = 0; p < 2; p++) begin
            expect_pulse(0, 0, P_LO, P_HI);
            bt_in[0] = 1'b1;
            repeat (20) @(negedge sys_clk);
            bt_in[0] = 1'b0;
            repeat (30) @(negedge sys_clk);
            check("t5_tog_seq", 32'(tog_state[0]), 32'((p == 0) ? 1 : 0));
        end
        expect_pulse(0, 0, P_LO, P_HI);
        bt_in[0] = 1'b1;
        seen = 1'b0;
        for (int j = 0; j < 30 && !seen; j++) begin
            @(negedge sys_clk);
            if (press_pulse[0]) begin
                seen = 1'b1;
                tog_clr[0] = 1'b1;
                @(negedge sys_clk);
                tog_clr[0] = 1'b0;
            end
        end
        check("t5_pulse_seen", 32'(seen), 32'd1);
        repeat (5) @(negedge sys_clk);
        bt_in[0] = 1'b0;
        repeat (30) @(negedge sys_clk);
        check("t5_clr_wins", 32'(tog_state[0]), 32'd0);
        check("t5_queue", exp_q.size(), 32'd0);
        $display("step 5 toggle sequence done");

        // 6: reset mid-hold, release with the button still down.
        expect_pulse(0, 0, P_LO, P_HI);
        bt_in[0] = 1'b1;
        repeat (20) @(negedge sys_clk);
        check("t6_tog_before", 32'(tog_state[0]), 32'd1);
        rst_sw = 1'b1;
        #1;
        check("t6_async_reset", {tick, btn_level, press_pulse, long_pulse, tog_state}, 32'd0);
        repeat (3) @(negedge sys_clk);
        check("t6_in_reset", {tick, btn_level, press_pulse, long_pulse, tog_state}, 32'd0);
        check("t6_queue_pre", exp_q.size(), 32'd0);
        expect_pulse(0, 0, P_LO, P_HI);
        rst_sw = 1'b0;
        repeat (20) @(negedge sys_clk);
        check("t6_level_again", 32'(btn_level[0]), 32'd1);
        check("t6_tog_again", 32'(tog_state[0]), 32'd1);
        bt_in[0] = 1'b0;
        repeat (30) @(negedge sys_clk);
        check("t6_queue", exp_q.size(), 32'd0);
        $display("step 6 reset mid-press done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
